image_proc_ctrl: RTL and testbench
==================================

// Module: image_proc_ctrl
// PURPOSE
//  Frame sequencer in front of image_proc (3x3 Sobel). Tracks x/y raster position from iFVAL/iDVAL.
//  Latches mode/conv-enable requests only at frame start (no mid-frame kernel switch).
//  Flags line-buffer priming rows and border pixels so downstream can mask invalid edge output.
//  Reports frame start/end and raster errors.
// PARAMETERS
//  W         640  active pixels per row
//  H         480  active rows per frame
//  KROWS     2    rows required to prime image_proc line buffers
//  FLUSH_CYC 8    cycles held in FLUSH after frame end (datapath drain)
// PORTS
//  iCLK          in   1           clock
//  iRST          in   1           synchronous reset, active-high
//  iFVAL         in   1           frame valid from sensor
//  iDVAL         in   1           pixel valid (one pixel per cycle when high)
//  iMODE_REQ     in   1           requested image_proc mode
//  iCONV_EN_REQ  in   1           requested convolution enable
//  oMODE         out  1           frame-stable mode to image_proc.iMODE
//  oCONV_EN      out  1           frame-stable enable to image_proc.iCONV_EN
//  oX            out  $clog2(W)   column of current iDVAL pixel
//  oY            out  $clog2(H+1) row of current iDVAL pixel
//  oPRIME        out  1           high while state==PRIME
//  oBORDER       out  1           current pixel is border (row<KROWS or col<KROWS)
//  oSOF          out  1           1-cycle pulse on frame accept
//  oEOF          out  1           1-cycle pulse on FLUSH->IDLE
//  oERR          out  3           sticky: [0] short row, [1] too many rows, [2] frame dropped
//  oFRAME_CNT    out  16          frames completed, wraps at 65535->0
// BEHAVIOUR
//  - Reset (iRST=1 at posedge): state=IDLE. All outputs 0. iFVAL edge detector cleared to 0.
//  - States: IDLE, PRIME, RUN, FLUSH.
//  - IDLE->PRIME on iFVAL rising edge (registered prev=0, now=1).
//    Same edge: oMODE<=iMODE_REQ, oCONV_EN<=iCONV_EN_REQ, x=y=0, oERR<=0, oSOF=1 next cycle.
//  - PRIME/RUN: each iDVAL=1 cycle advances x. When x==W-1: x<=0, y<=y+1. iDVAL=0 holds counters.
//  - PRIME->RUN when the row wrap takes y from KROWS-1 to KROWS.
//  - PRIME or RUN -> FLUSH on iFVAL falling edge.
//    Short row: if x!=0 at the edge, set oERR[0].
//    Falling edge during PRIME is legal; it only flags oERR[0] when x!=0.
//  - Too many rows: iDVAL=1 while y==H sets oERR[1]. That pixel is not counted and y saturates at H.
//  - FLUSH: counts FLUSH_CYC cycles, ignores iDVAL, then ->IDLE.
//    On FLUSH->IDLE: oEOF pulse, oFRAME_CNT+1.
//  - iFVAL rising edge during FLUSH: set oERR[2]. That frame is dropped.
//    IDLE needs a fresh rising edge, so the current high iFVAL is not accepted.
//  - oX/oY/oBORDER: combinational from counter regs + iDVAL, aligned with the input pixel (0 latency).
//    oBORDER = iDVAL & (y<KROWS | x<KROWS). oBORDER is 0 when iDVAL=0.
//  - iMODE_REQ/iCONV_EN_REQ changes outside the IDLE->PRIME edge have no effect on oMODE/oCONV_EN.
//  - Reset mid-frame: immediate IDLE. Frame in progress is abandoned (no oEOF, no count increment).
//    A still-high iFVAL is not accepted until it falls and rises again.
// STRUCTURE
//  - Package image_proc_pkg: state enum ctrl_state_e {IDLE,PRIME,RUN,FLUSH}, ERR_* bit index localparams.
//    The same package holds the default W/H constants shared with image_proc.
//  - Sub-module raster_cnt: x/y counters with wrap and y saturation; inputs adv/clr.
//    Outputs x, y, row_wrap, y_full.
//  - FSM, edge detect, flush counter, config shadow registers and error logic in the top.
// TESTING (W=8, H=4, KROWS=2, FLUSH_CYC=3)
//  - Reset, then FVAL 0->1 with MODE_REQ=1, 32 DVAL pulses, FVAL falls
//    -> oSOF once, oMODE=1, oPRIME high for first 16 pixels, oEOF 3 cycles after fall, oFRAME_CNT=1.
//  - Toggle iMODE_REQ 1->0 mid-frame -> oMODE stays 1 until next frame start, then 0.
//  - Border check: first pixel of row 2 (x=0,y=2) -> oBORDER=1; x=2,y=2 -> oBORDER=0; x=5,y=1 -> 1.
//  - FVAL falls after 13 pixels -> oERR=3'b001, FLUSH entered, oEOF still pulses.
//  - 40 DVAL pulses in one frame -> oERR[1]=1 on pixel 33, oY holds 4.
//  - FVAL rises during FLUSH -> oERR[2]=1, no oSOF. After FVAL fall+rise -> oSOF, oERR cleared.
//  - Assert iRST mid-RUN -> next cycle all outputs 0, state IDLE, oFRAME_CNT=0.

Source files
------------

// File: rtl/image_proc_pkg.sv
// rtl/image_proc_pkg.sv - shared types and constants for the image_proc front end
//
// Purpose : sequencer state encoding, error-bit positions and the default
//           frame geometry shared by image_proc_ctrl and image_proc.
package image_proc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } ctrl_state_e;

   // oERR bit positions
   localparam int ERR_SHORT_ROW = 0;
   localparam int ERR_TOO_MANY  = 1;
   localparam int ERR_DROPPED   = 2;

   // default frame geometry and pipeline depths
   localparam int IMG_W       = 640;
   localparam int IMG_H       = 480;
   localparam int IMG_KROWS   = 2;
   localparam int IMG_FLUSH   = 8;

endpackage

// File: rtl/raster_cnt.sv
// rtl/raster_cnt.sv - x/y raster position counters with row wrap and y saturation
//
// Purpose : column counter wraps at W-1 and carries into the row counter;
//           the row counter stops at H so surplus pixels are never counted.
// Ports   : iCLK, iRST     clock, synchronous active-high reset
//           i_clr          restart at (0,0) for a new frame
//           i_adv          one pixel accepted this cycle
//           o_x, o_y       current column / row
//           o_row_wrap     this pixel is the last of a row and advances y
//           o_y_full       y has reached H (no more rows accepted)
module raster_cnt #(
   parameter int W  = 640,
   parameter int H  = 480,
   parameter int XW = $clog2(W),
   parameter int YW = $clog2(H + 1)
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          i_clr,
   input  logic          i_adv,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_row_wrap,
   output logic          o_y_full
);

   localparam logic [XW-1:0] X_LAST = XW'(W - 1);
   localparam logic [YW-1:0] Y_MAX  = YW'(H);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_adv;

   assign o_y_full   = (r_y == Y_MAX);
   assign w_adv      = i_adv & ~o_y_full;
   assign o_row_wrap = w_adv & (r_x == X_LAST);
   assign o_x        = r_x;
   assign o_y        = r_y;

   always_ff @(posedge iCLK) begin
      if (iRST || i_clr) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_adv) begin
         if (o_row_wrap) begin
            r_x <= '0;
            r_y <= r_y + YW'(1);
         end else begin
            r_x <= r_x + XW'(1);
         end
      end
   end

endmodule

// File: rtl/image_proc_ctrl.sv
// rtl/image_proc_ctrl.sv - frame sequencer in front of the image_proc Sobel datapath
//
// Purpose : tracks raster position from iFVAL/iDVAL, freezes mode/enable at
//           frame start, flags priming rows and border pixels, reports
//           frame start/end, frame count and sticky raster errors.
// Ports   : iCLK, iRST            clock, synchronous active-high reset
//           iFVAL, iDVAL          frame / pixel valid from sensor
//           iMODE_REQ, iCONV_EN_REQ  requested config, sampled at frame start
//           oMODE, oCONV_EN       frame-stable config to image_proc
//           oX, oY                position of the current iDVAL pixel
//           oPRIME                line buffers still priming
//           oBORDER               current pixel lies in the invalid edge band
//           oSOF, oEOF            frame accepted / frame drained pulses
//           oERR                  sticky {dropped, too many rows, short row}
//           oFRAME_CNT            frames completed (wrapping)
module image_proc_ctrl
   import image_proc_pkg::*;
#(
   parameter int W         = IMG_W,
   parameter int H         = IMG_H,
   parameter int KROWS     = IMG_KROWS,
   parameter int FLUSH_CYC = IMG_FLUSH
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iFVAL,
   input  logic                   iDVAL,
   input  logic                   iMODE_REQ,
   input  logic                   iCONV_EN_REQ,
   output logic                   oMODE,
   output logic                   oCONV_EN,
   output logic [$clog2(W)-1:0]   oX,
   output logic [$clog2(H+1)-1:0] oY,
   output logic                   oPRIME,
   output logic                   oBORDER,
   output logic                   oSOF,
   output logic                   oEOF,
   output logic [2:0]             oERR,
   output logic [15:0]            oFRAME_CNT
);

   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H + 1);
   localparam int FW = $clog2(FLUSH_CYC + 1);

   localparam logic [XW-1:0] X_KROWS      = XW'(KROWS);
   localparam logic [YW-1:0] Y_KROWS      = YW'(KROWS);
   localparam logic [YW-1:0] Y_PRIME_LAST = YW'(KROWS - 1);
   localparam logic [FW-1:0] FLUSH_LAST   = FW'(FLUSH_CYC - 1);

   ctrl_state_e   r_state, w_state_nxt;
   logic          r_fval_prev;
   logic          r_armed;
   logic          r_mode, r_conv_en, r_sof, r_eof;
   logic [2:0]    r_err;
   logic [15:0]   r_frame_cnt;
   logic [FW-1:0] r_flush_cnt;

   logic          w_rise, w_fall, w_active, w_adv;
   logic          w_accept, w_go_flush, w_flush_done;
   logic [XW-1:0] w_x;
   logic [YW-1:0] w_y;
   logic          w_row_wrap, w_y_full;

   assign w_rise   = iFVAL & ~r_fval_prev;
   assign w_fall   = ~iFVAL & r_fval_prev;
   assign w_active = (r_state == PRIME) || (r_state == RUN);
   // the falling-edge cycle belongs to FLUSH, so a pixel there is not counted
   assign w_adv    = w_active & iDVAL & ~w_fall;

   raster_cnt #(.W(W), .H(H), .XW(XW), .YW(YW)) u_raster (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .i_clr      (w_accept),
      .i_adv      (w_adv),
      .o_x        (w_x),
      .o_y        (w_y),
      .o_row_wrap (w_row_wrap),
      .o_y_full   (w_y_full)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_go_flush   = 1'b0;
      w_flush_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise && r_armed) begin
               w_state_nxt = PRIME;
               w_accept    = 1'b1;
            end
         end
         PRIME, RUN: begin
            if (w_fall) begin
               w_state_nxt = FLUSH;
               w_go_flush  = 1'b1;
            end else if ((r_state == PRIME) && w_row_wrap && (w_y == Y_PRIME_LAST)) begin
               w_state_nxt = RUN;
            end
         end
         FLUSH: begin
            if (r_flush_cnt == FLUSH_LAST) begin
               w_state_nxt  = IDLE;
               w_flush_done = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // r_armed stays low after reset until iFVAL has been seen low, so a frame
   // already in flight when reset released is never picked up half-way.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_fval_prev <= 1'b0;
         r_armed     <= 1'b0;
         r_mode      <= 1'b0;
         r_conv_en   <= 1'b0;
         r_sof       <= 1'b0;
         r_eof       <= 1'b0;
         r_err       <= '0;
         r_frame_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_fval_prev <= iFVAL;
         if (!iFVAL) r_armed <= 1'b1;
         r_sof <= w_accept;
         r_eof <= w_flush_done;
         if (w_accept) begin
            r_mode    <= iMODE_REQ;
            r_conv_en <= iCONV_EN_REQ;
            r_err     <= '0;
         end
         if (w_go_flush && (w_x != '0)) r_err[ERR_SHORT_ROW] <= 1'b1;
         if (w_adv && w_y_full)         r_err[ERR_TOO_MANY]  <= 1'b1;
         if ((r_state == FLUSH) && w_rise) r_err[ERR_DROPPED] <= 1'b1;
         if (r_state == FLUSH) r_flush_cnt <= r_flush_cnt + FW'(1);
         else                  r_flush_cnt <= '0;
         if (w_flush_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign oMODE      = r_mode;
   assign oCONV_EN   = r_conv_en;
   assign oX         = w_x;
   assign oY         = w_y;
   assign oPRIME     = (r_state == PRIME);
   assign oBORDER    = iDVAL & ((w_y < Y_KROWS) | (w_x < X_KROWS));
   assign oSOF       = r_sof;
   assign oEOF       = r_eof;
   assign oERR       = r_err;
   assign oFRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_image_proc_ctrl.sv
// tb/tb_image_proc_ctrl.sv - directed scoreboard bench for image_proc_ctrl
module tb_image_proc_ctrl;

   localparam int W         = 8;
   localparam int H         = 4;
   localparam int KROWS     = 2;
   localparam int FLUSH_CYC = 3;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
      logic       b;
      logic       p;
   } pix_t;

   logic        iCLK, iRST, iFVAL, iDVAL, iMODE_REQ, iCONV_EN_REQ;
   logic        oMODE, oCONV_EN, oPRIME, oBORDER, oSOF, oEOF;
   logic [2:0]  oX;
   logic [2:0]  oY;
   logic [2:0]  oERR;
   logic [15:0] oFRAME_CNT;

   int n_cmp = 0;
   int n_err = 0;
   int sof_cnt = 0;
   int m_x, m_y;
   bit m_prime;
   pix_t sb[$];

   image_proc_ctrl #(.W(W), .H(H), .KROWS(KROWS), .FLUSH_CYC(FLUSH_CYC)) dut (
      .iCLK         (iCLK),
      .iRST         (iRST),
      .iFVAL        (iFVAL),
      .iDVAL        (iDVAL),
      .iMODE_REQ    (iMODE_REQ),
      .iCONV_EN_REQ (iCONV_EN_REQ),
      .oMODE        (oMODE),
      .oCONV_EN     (oCONV_EN),
      .oX           (oX),
      .oY           (oY),
      .oPRIME       (oPRIME),
      .oBORDER      (oBORDER),
      .oSOF         (oSOF),
      .oEOF         (oEOF),
      .oERR         (oERR),
      .oFRAME_CNT   (oFRAME_CNT)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   always @(negedge iCLK) if (oSOF === 1'b1) sof_cnt++;

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge iCLK);
      #1;
   endtask

   task automatic start_frame(input logic mode, input logic conv);
      iMODE_REQ    = mode;
      iCONV_EN_REQ = conv;
      iFVAL        = 1'b1;
      m_x = 0; m_y = 0; m_prime = 1'b1;
      next();
      @(negedge iCLK);
      chk("sof", oSOF, 1);
      chk("mode_latch", oMODE, mode);
      chk("conv_latch", oCONV_EN, conv);
      chk("err_clear", oERR, 0);
      next();
      @(negedge iCLK);
      chk("sof_single", oSOF, 0);
      next();
   endtask

   task automatic pixel();
      pix_t e, o;
      e.x = 3'(m_x);
      e.y = 3'(m_y);
      e.b = (m_y < KROWS) || (m_x < KROWS);
      e.p = m_prime;
      sb.push_back(e);
      iDVAL = 1'b1;
      @(negedge iCLK);
      o = {oX, oY, oBORDER, oPRIME};
      e = sb.pop_front();
      chk("pix_x", o.x, e.x);
      chk("pix_y", o.y, e.y);
      chk("pix_border", o.b, e.b);
      chk("pix_prime", o.p, e.p);
      if (m_y != H) begin
         if (m_x == W - 1) begin
            m_x = 0;
            m_y++;
            if (m_y == KROWS) m_prime = 1'b0;
         end else begin
            m_x++;
         end
      end
      @(posedge iCLK);
      #1;
      iDVAL = 1'b0;
   endtask

   // drop iFVAL, optionally re-raise it while draining, and expect oEOF
   // FLUSH_CYC cycles after the edge at which the fall is registered
   task automatic end_frame(input bit refire, input int exp_cnt);
      int lat;
      bit seen;
      seen  = 1'b0;
      iFVAL = 1'b0;
      iDVAL = 1'b0;
      for (lat = 1; lat <= 12; lat++) begin
         next();
         if (refire && lat == 1) iFVAL = 1'b1;
         @(negedge iCLK);
         if (oEOF === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("eof_timeout", 0, 1);
      else begin
         chk("eof_latency", lat, FLUSH_CYC + 1);
         chk("frame_cnt", oFRAME_CNT, exp_cnt);
      end
      next();
      @(negedge iCLK);
      chk("eof_single", oEOF, 0);
      next();
   endtask

   initial begin
      int sof_snap;
      iRST = 1'b1; iFVAL = 1'b0; iDVAL = 1'b0;
      iMODE_REQ = 1'b0; iCONV_EN_REQ = 1'b0;
      next(); next();
      iRST = 1'b0;
      @(negedge iCLK);
      chk("rst_mode", oMODE, 0);
      chk("rst_conv", oCONV_EN, 0);
      chk("rst_x", oX, 0);
      chk("rst_y", oY, 0);
      chk("rst_prime", oPRIME, 0);
      chk("rst_border", oBORDER, 0);
      chk("rst_sof", oSOF, 0);
      chk("rst_eof", oEOF, 0);
      chk("rst_err", oERR, 0);
      chk("rst_fcnt", oFRAME_CNT, 0);
      next(); next();

      // frame 1: full frame, mode request changes mid-frame
      start_frame(1'b1, 1'b0);
      repeat (10) pixel();
      iMODE_REQ = 1'b0;
      repeat (22) pixel();
      @(negedge iCLK);
      chk("mode_stable", oMODE, 1);
      next();
      end_frame(1'b0, 1);
      @(negedge iCLK);
      chk("f1_err", oERR, 0);
      chk("f1_sofs", sof_cnt, 1);
      next();

      // frame 2: new mode taken, short row of 13 pixels
      start_frame(1'b0, 1'b1);
      repeat (13) pixel();
      end_frame(1'b0, 2);
      @(negedge iCLK);
      chk("short_row_err", oERR, 3'b001);
      next();

      // frame 3: 40 pixels, rows overflow at pixel 33
      start_frame(1'b1, 1'b1);
      repeat (32) pixel();
      @(negedge iCLK);
      chk("err_before_overflow", oERR, 0);
      next();
      pixel();
      @(negedge iCLK);
      chk("err_overflow", oERR, 3'b010);
      next();
      repeat (7) pixel();
      end_frame(1'b0, 3);

      // frame 4: iFVAL re-rises during FLUSH and is dropped
      start_frame(1'b0, 1'b0);
      repeat (8) pixel();
      end_frame(1'b1, 4);
      @(negedge iCLK);
      chk("drop_err", oERR, 3'b100);
      sof_snap = sof_cnt;
      next();
      repeat (4) next();
      @(negedge iCLK);
      chk("drop_no_sof", sof_cnt, sof_snap);
      chk("drop_idle_prime", oPRIME, 0);
      next();
      iFVAL = 1'b0;
      next(); next();

      // frame 5: accepted after fresh edge, reset while in RUN
      start_frame(1'b1, 1'b1);
      repeat (17) pixel();
      iRST = 1'b1;
      next();
      iRST = 1'b0;
      @(negedge iCLK);
      chk("mrst_mode", oMODE, 0);
      chk("mrst_conv", oCONV_EN, 0);
      chk("mrst_x", oX, 0);
      chk("mrst_y", oY, 0);
      chk("mrst_prime", oPRIME, 0);
      chk("mrst_eof", oEOF, 0);
      chk("mrst_err", oERR, 0);
      chk("mrst_fcnt", oFRAME_CNT, 0);
      sof_snap = sof_cnt;
      next();
      repeat (4) next();
      @(negedge iCLK);
      chk("mrst_no_sof", sof_cnt, sof_snap);
      chk("mrst_idle_prime", oPRIME, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
